imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//  Parametrised, registered immediate generator for the RISC-V datapath.
//  Extracts and sign-/zero-extends the immediate for every base format (I,S,B,U,J,shamt) at XLEN width.
//  Selects the format either from an explicit imm_sel or by self-decoding the opcode.
//  Sits between instruction fetch/decode and the ALU operand mux; valid/ready with a 2-entry skid buffer.
// PARAMETERS
//  XLEN         32  immediate output width; legal values 32 or 64
//  AUTO_DECODE  0   1: ignore in_imm_sel and derive the format from in_instr[6:0]
//  CNT_W        16  width of the saturating format-error counter
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        synchronous reset, active low
//  in_valid     in   1        in_instr/in_imm_sel valid
//  in_ready     out  1        block can accept this cycle
//  in_instr     in   32       raw instruction word
//  in_imm_sel   in   3        format select (ignored when AUTO_DECODE=1)
//  out_valid    out  1        out_imm/out_fmt_err valid
//  out_ready    in   1        consumer accepts this cycle
//  out_imm      out  XLEN     generated immediate
//  out_fmt_err  out  1        unsupported select or unknown opcode; out_imm=0
//  err_cnt      out  CNT_W    count of accepted beats with fmt_err, saturating
// BEHAVIOUR
//  One clock. Reset is synchronous, active low: rst_n sampled low at a clk edge clears all state.
//  Reset values: out_valid=0, out_imm=0, out_fmt_err=0, err_cnt=0, skid empty.
//  in_ready=0 while rst_n=0; otherwise in_ready = !skid_valid.
//  imm_sel codes (S = sign-extend from instr[31] to XLEN):
//   000 R     -> 0
//   001 I     -> S{[31:20]}
//   010 S     -> S{[31:25],[11:7]}
//   011 U     -> S{[31:12],12'b0}
//   100 B     -> S{[31],[7],[30:25],[11:8],1'b0}
//   101 J     -> S{[31],[19:12],[20],[30:21],1'b0}
//   110 SHAMT -> zero-ext [25:20] if XLEN=64, else [24:20]
//   111       -> 0, fmt_err=1
//  AUTO_DECODE opcode map:
//   0110011 -> R
//   0010011 -> I, but SHAMT when funct3 is 001 or 101
//   0000011, 1100111, 1110011 -> I
//   0100011 -> S;  1100011 -> B;  0110111, 0010111 -> U;  1101111 -> J
//   any other opcode -> fmt_err
//  Datapath: the immediate is computed combinationally from the input and captured in the out reg or the skid reg.
//  Latency: accept at edge N -> out_valid from N (visible the following cycle). Throughput 1 beat/cycle.
//  Transfer: in on in_valid&in_ready; out on out_valid&out_ready.
//  Out-reg load condition: out reg empty, or out_ready=1 (its beat leaves). When it loads:
//   - from the skid reg if skid_valid;
//   - else from the input on accept;
//   - else out_valid goes to 0.
//  Skid load: accept while the out reg is held (out_valid&!out_ready) -> beat goes to the skid reg.
//  At most 2 beats are buffered; strict in-order delivery; no beat is dropped or duplicated.
//  out_imm/out_fmt_err stay stable while out_valid&!out_ready.
//  err_cnt increments on each accepted beat with fmt_err; it holds at 2^CNT_W-1.
//  Reset mid-operation discards both buffered beats; nothing is emitted after reset.
// TESTING
//  1 I, sel=001, 0xFFF00093 -> out_imm=0xFFFFFFFF one cycle after accept; fmt_err=0.
//  2 B/U/J:
//    sel=100, 0xFE000EE3 -> 0xFFFFFFFC
//    sel=011, 0x123450B7 -> 0x12345000
//    sel=101, 0x0080006F -> 0x00000008
//  3 XLEN=64, AUTO_DECODE=1:
//    0x80000037 -> 0xFFFFFFFF80000000
//    slli 0x03F09093 -> 0x3F
//    opcode 0x7F -> fmt_err=1, imm=0
//  4 Backpressure: out_ready=0, push A,B,C back-to-back.
//    -> A held in out, B in skid, in_ready=0 while C waits.
//    -> raise out_ready: A,B,C delivered in order on consecutive cycles.
//  5 sel=111 x3 -> err_cnt=3. Preload at 0xFFFF, one more error -> err_cnt stays 0xFFFF.
//  6 Both regs full, rst_n=0 for one edge -> out_valid=0, err_cnt=0, in_ready=1 next cycle, old beats never appear.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator (I/S/B/U/J/shamt) with an XLEN-wide output.
// Latency: an accepted beat is presented on out_* from the next cycle; throughput is 1 beat/cycle.
// Backpressure: an output register plus a 1-deep skid register; in_ready drops only when the skid is full.
module imm_gen_pipe #(
  parameter int XLEN        = 32,  // 32 or 64
  parameter int AUTO_DECODE = 0,   // 1: derive the format from the opcode
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_fmt_err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [2:0] SEL_R     = 3'b000;
  localparam logic [2:0] SEL_I     = 3'b001;
  localparam logic [2:0] SEL_S     = 3'b010;
  localparam logic [2:0] SEL_U     = 3'b011;
  localparam logic [2:0] SEL_B     = 3'b100;
  localparam logic [2:0] SEL_J     = 3'b101;
  localparam logic [2:0] SEL_SHAMT = 3'b110;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [2:0]        sel;
  logic              dec_err;
  logic signed [31:0] imm32;
  logic [XLEN-1:0]   imm_nxt;
  logic              err_nxt;

  logic [XLEN-1:0]   skid_imm;
  logic              skid_err;
  logic              skid_valid;

  logic              accept;
  logic              out_load;

  // Format select: explicit select, or self-decoded from the opcode.
  always_comb begin
    sel     = in_imm_sel;
    dec_err = 1'b0;
    if (AUTO_DECODE != 0) begin
      sel = SEL_R;
      case (in_instr[6:0])
        7'b0110011: sel = SEL_R;
        // OP-IMM shifts (funct3 001/101) carry a shift amount instead of an I immediate.
        7'b0010011: sel = (in_instr[13:12] == 2'b01) ? SEL_SHAMT : SEL_I;
        7'b0000011,
        7'b1100111,
        7'b1110011: sel = SEL_I;
        7'b0100011: sel = SEL_S;
        7'b1100011: sel = SEL_B;
        7'b0110111,
        7'b0010111: sel = SEL_U;
        7'b1101111: sel = SEL_J;
        default:    dec_err = 1'b1;
      endcase
    end
  end

  // Immediate extraction; built at 32 bits then sign-extended to XLEN.
  always_comb begin
    err_nxt = dec_err;
    case (sel)
      SEL_R:     imm32 = '0;
      SEL_I:     imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      SEL_S:     imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      SEL_U:     imm32 = {in_instr[31:12], 12'b0};
      SEL_B:     imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                          in_instr[30:25], in_instr[11:8], 1'b0};
      SEL_J:     imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                          in_instr[20], in_instr[30:21], 1'b0};
      // Top bit is always zero here, so the later sign extension is a zero extension.
      SEL_SHAMT: imm32 = (XLEN == 64) ? {26'b0, in_instr[25:20]}
                                      : {27'b0, in_instr[24:20]};
      default: begin
        imm32   = '0;
        err_nxt = 1'b1;
      end
    endcase
    if (err_nxt) imm32 = '0;
    imm_nxt = XLEN'(imm32);
  end

  // Skid full blocks the input; reset holds it off entirely.
  assign in_ready = rst_n & ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign out_load = ~out_valid | out_ready;

  // Output/skid registers: skid drains first to keep beats in order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_imm     <= '0;
      out_fmt_err <= 1'b0;
      skid_valid  <= 1'b0;
      skid_imm    <= '0;
      skid_err    <= 1'b0;
    end else if (out_load) begin
      if (skid_valid) begin
        out_valid   <= 1'b1;
        out_imm     <= skid_imm;
        out_fmt_err <= skid_err;
        skid_valid  <= 1'b0;
      end else if (accept) begin
        out_valid   <= 1'b1;
        out_imm     <= imm_nxt;
        out_fmt_err <= err_nxt;
      end else begin
        out_valid   <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_imm   <= imm_nxt;
      skid_err   <= err_nxt;
    end
  end

  // Saturating count of accepted beats flagged with a format error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (accept && err_nxt && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: directed format vectors, backpressure, counter saturation,
// mid-stream reset, and a randomized stream scored against a queue-based model.
// Three instances: 32-bit explicit select, 32-bit with a 4-bit counter, 64-bit auto-decode.
module tb_imm_gen_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [2:0]  in_imm_sel;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, out_fmt_err_a;
  logic [31:0] out_imm_a;
  logic [15:0] err_cnt_a;

  logic        in_ready_s, out_valid_s, out_fmt_err_s;
  logic [31:0] out_imm_s;
  logic [3:0]  err_cnt_s;

  logic        in_valid_w, out_ready_w;
  logic [31:0] in_instr_w;
  logic [2:0]  in_imm_sel_w;
  logic        in_ready_w, out_valid_w, out_fmt_err_w;
  logic [63:0] out_imm_w;
  logic [15:0] err_cnt_w;

  int checks;
  int failures;

  imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(0), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_instr(in_instr), .in_imm_sel(in_imm_sel), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_imm(out_imm_a), .out_fmt_err(out_fmt_err_a),
    .err_cnt(err_cnt_a));

  imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(0), .CNT_W(4)) u_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_instr(in_instr), .in_imm_sel(in_imm_sel), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_imm(out_imm_s), .out_fmt_err(out_fmt_err_s),
    .err_cnt(err_cnt_s));

  imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1), .CNT_W(16)) u_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .in_instr(in_instr_w), .in_imm_sel(in_imm_sel_w), .out_valid(out_valid_w),
    .out_ready(out_ready_w), .out_imm(out_imm_w), .out_fmt_err(out_fmt_err_w),
    .err_cnt(err_cnt_w));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {fmt_err, 64-bit immediate} from the format rules, using field value
  // minus 2^width for negative numbers.
  function automatic logic [64:0] model(input logic [31:0] ins, input logic [2:0] sel_in,
                                        input bit x64, input bit autod);
    logic [2:0] f;
    bit         err;
    longint     v;
    f = sel_in; err = 0; v = 0;
    if (autod) begin
      case (ins[6:0])
        7'h33:             f = 3'd0;
        7'h13:             f = (ins[14:12] == 3'b001 || ins[14:12] == 3'b101) ? 3'd6 : 3'd1;
        7'h03, 7'h67, 7'h73: f = 3'd1;
        7'h23:             f = 3'd2;
        7'h63:             f = 3'd4;
        7'h37, 7'h17:      f = 3'd3;
        7'h6F:             f = 3'd5;
        default:           err = 1;
      endcase
    end
    if (!err) begin
      case (f)
        3'd0: v = 0;
        3'd1: begin v = ins[31:20]; if (ins[31]) v = v - 4096; end
        3'd2: begin v = {ins[31:25], ins[11:7]}; if (ins[31]) v = v - 4096; end
        3'd3: begin v = ins[31:12]; v = v * 4096; if (ins[31]) v = v - (longint'(1) << 32); end
        3'd4: begin v = {ins[31], ins[7], ins[30:25], ins[11:8]}; v = v * 2;
                    if (ins[31]) v = v - 8192; end
        3'd5: begin v = {ins[31], ins[19:12], ins[20], ins[30:21]}; v = v * 2;
                    if (ins[31]) v = v - 2097152; end
        3'd6: v = x64 ? longint'(ins[25:20]) : longint'(ins[24:20]);
        default: err = 1;
      endcase
    end
    if (err) v = 0;
    return {err, v};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; in_valid_w = 1'b0;
    out_ready = 1'b1; out_ready_w = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Present one beat for a single cycle; returns #1 after the next negedge.
  task automatic push32(input logic [31:0] ins, input logic [2:0] sel);
    @(negedge clk);
    in_valid = 1'b1; in_instr = ins; in_imm_sel = sel; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
  endtask

  task automatic push64(input logic [31:0] ins);
    @(negedge clk);
    in_valid_w = 1'b1; in_instr_w = ins; in_imm_sel_w = 3'b111; out_ready_w = 1'b1;
    @(negedge clk);
    in_valid_w = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_valid_w = 1'b0;
    in_instr = '0; in_imm_sel = '0; out_ready = 1'b0;
    in_instr_w = '0; in_imm_sel_w = '0; out_ready_w = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (out_valid_a !== 1'b0 || out_imm_a !== 32'h0 || out_fmt_err_a !== 1'b0 || err_cnt_a !== 16'h0) begin
      failures++;
      $display("FAIL reset_state got v=%b imm=%h err=%b cnt=%h want 0/0/0/0",
               out_valid_a, out_imm_a, out_fmt_err_a, err_cnt_a);
    end
    checks++;
    if (in_ready_a !== 1'b0 || in_ready_w !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_ready got %b/%b want 0/0", in_ready_a, in_ready_w);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready_a !== 1'b1) begin
      failures++;
      $display("FAIL release_in_ready got %b want 1", in_ready_a);
    end
  endtask

  task automatic test_i_format();
    push32(32'hFFF00093, 3'b001);
    checks++;
    if (out_valid_a !== 1'b1 || out_imm_a !== 32'hFFFFFFFF || out_fmt_err_a !== 1'b0) begin
      failures++;
      $display("FAIL i_format got v=%b imm=%h err=%b want 1/ffffffff/0",
               out_valid_a, out_imm_a, out_fmt_err_a);
    end
  endtask

  task automatic test_buj_formats();
    logic [31:0] ins_t [3];
    logic [2:0]  sel_t [3];
    logic [31:0] exp_t [3];
    ins_t = '{32'hFE000EE3, 32'h123450B7, 32'h0080006F};
    sel_t = '{3'b100, 3'b011, 3'b101};
    exp_t = '{32'hFFFFFFFC, 32'h12345000, 32'h00000008};
    for (int i = 0; i < 3; i++) begin
      push32(ins_t[i], sel_t[i]);
      checks++;
      if (out_valid_a !== 1'b1 || out_imm_a !== exp_t[i] || out_fmt_err_a !== 1'b0) begin
        failures++;
        $display("FAIL buj_format[%0d] got v=%b imm=%h err=%b want 1/%h/0",
                 i, out_valid_a, out_imm_a, out_fmt_err_a, exp_t[i]);
      end
    end
  endtask

  task automatic test_auto_decode64();
    logic [31:0] ins_t [3];
    logic [63:0] exp_t [3];
    logic        err_t [3];
    ins_t = '{32'h80000037, 32'h03F09093, 32'h0000007F};
    exp_t = '{64'hFFFFFFFF80000000, 64'h000000000000003F, 64'h0};
    err_t = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      push64(ins_t[i]);
      checks++;
      if (out_valid_w !== 1'b1 || out_imm_w !== exp_t[i] || out_fmt_err_w !== err_t[i]) begin
        failures++;
        $display("FAIL auto64[%0d] got v=%b imm=%h err=%b want 1/%h/%b",
                 i, out_valid_w, out_imm_w, out_fmt_err_w, exp_t[i], err_t[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ia, ib, ic;
    logic [31:0] ea, eb, ec;
    ia = 32'h7FF00013; ib = 32'h80000037; ic = 32'hFE000EE3;
    ea = 32'h000007FF; eb = 32'h80000000; ec = 32'hFFFFFFFC;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_instr = ia; in_imm_sel = 3'b001;
    @(negedge clk);
    in_instr = ib; in_imm_sel = 3'b011;
    #1;
    checks++;
    if (in_ready_a !== 1'b1) begin
      failures++; $display("FAIL b2b_ready_b got %b want 1", in_ready_a);
    end
    @(negedge clk);
    in_instr = ic; in_imm_sel = 3'b100;
    #1;
    checks++;
    if (in_ready_a !== 1'b0 || out_valid_a !== 1'b1 || out_imm_a !== ea) begin
      failures++;
      $display("FAIL b2b_full got rdy=%b v=%b imm=%h want 0/1/%h", in_ready_a, out_valid_a, out_imm_a, ea);
    end
    @(negedge clk);
    #1;
    checks++;
    if (in_ready_a !== 1'b0 || out_imm_a !== ea) begin
      failures++;
      $display("FAIL b2b_hold got rdy=%b imm=%h want 0/%h", in_ready_a, out_imm_a, ea);
    end
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (out_valid_a !== 1'b1 || out_imm_a !== eb || in_ready_a !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second got v=%b imm=%h rdy=%b want 1/%h/1", out_valid_a, out_imm_a, in_ready_a, eb);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid_a !== 1'b1 || out_imm_a !== ec) begin
      failures++;
      $display("FAIL b2b_third got v=%b imm=%h want 1/%h", out_valid_a, out_imm_a, ec);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid_a !== 1'b0) begin
      failures++; $display("FAIL b2b_drained got v=%b want 0", out_valid_a);
    end
  endtask

  task automatic test_err_cnt();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push32($urandom, 3'b111);
      checks++;
      if (out_fmt_err_a !== 1'b1 || out_imm_a !== 32'h0) begin
        failures++;
        $display("FAIL err_beat[%0d] got err=%b imm=%h want 1/0", i, out_fmt_err_a, out_imm_a);
      end
    end
    checks++;
    if (err_cnt_a !== 16'd3 || err_cnt_s !== 4'd3) begin
      failures++;
      $display("FAIL err_cnt3 got %0d/%0d want 3/3", err_cnt_a, err_cnt_s);
    end
    @(negedge clk);
    in_valid = 1'b1; in_imm_sel = 3'b111; out_ready = 1'b1;
    repeat (14) @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (err_cnt_a !== 16'd17 || err_cnt_s !== 4'hF) begin
      failures++;
      $display("FAIL err_cnt_sat got %0d/%0d want 17/15", err_cnt_a, err_cnt_s);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0; in_imm_sel = 3'b111;
    @(negedge clk);
    in_imm_sel = 3'b111;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready_a !== 1'b0 || err_cnt_a !== 16'd2) begin
      failures++;
      $display("FAIL mid_full got rdy=%b cnt=%0d want 0/2", in_ready_a, err_cnt_a);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (out_valid_a !== 1'b0 || err_cnt_a !== 16'd0 || in_ready_a !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset got v=%b cnt=%0d rdy=%b want 0/0/1", out_valid_a, err_cnt_a, in_ready_a);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (out_valid_a !== 1'b0) begin
        failures++; $display("FAIL mid_ghost[%0d] got v=%b want 0", i, out_valid_a);
      end
    end
  endtask

  task automatic test_random();
    logic [64:0] qa [$];
    logic [64:0] qw [$];
    logic [64:0] e;
    logic [6:0]  ops [10];
    int          na, nw, ecnt_a, ecnt_w, idx;
    bit          acc_a, acc_w;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    ecnt_a = 0; ecnt_w = 0;
    do_reset();
    for (int cyc = 0; cyc < 340; cyc++) begin
      @(negedge clk);
      if (cyc < 300) begin
        in_valid    = ($urandom_range(0, 3) != 0);
        in_instr    = $urandom;
        in_imm_sel  = 3'($urandom_range(0, 7));
        out_ready   = ($urandom_range(0, 2) != 0);
        in_valid_w  = ($urandom_range(0, 3) != 0);
        in_instr_w  = $urandom;
        idx = $urandom_range(0, 10);
        if (idx < 10) in_instr_w[6:0] = ops[idx];
        in_imm_sel_w = 3'($urandom_range(0, 7));
        out_ready_w = ($urandom_range(0, 2) != 0);
      end else begin
        in_valid = 1'b0; in_valid_w = 1'b0; out_ready = 1'b1; out_ready_w = 1'b1;
      end
      #1;
      na = qa.size(); nw = qw.size();
      acc_a = in_valid && (na < 2);
      acc_w = in_valid_w && (nw < 2);
      checks++;
      if (in_ready_a !== (na < 2) || out_valid_a !== (na > 0)) begin
        failures++;
        $display("FAIL rnd32_flow cyc=%0d got rdy=%b v=%b want %b/%b", cyc, in_ready_a, out_valid_a, na < 2, na > 0);
      end
      checks++;
      if (in_ready_w !== (nw < 2) || out_valid_w !== (nw > 0)) begin
        failures++;
        $display("FAIL rnd64_flow cyc=%0d got rdy=%b v=%b want %b/%b", cyc, in_ready_w, out_valid_w, nw < 2, nw > 0);
      end
      if (na > 0 && out_ready) begin
        e = qa.pop_front();
        checks++;
        if (out_imm_a !== e[31:0] || out_fmt_err_a !== e[64]) begin
          failures++;
          $display("FAIL rnd32_beat cyc=%0d got imm=%h err=%b want %h/%b", cyc, out_imm_a, out_fmt_err_a, e[31:0], e[64]);
        end
      end
      if (nw > 0 && out_ready_w) begin
        e = qw.pop_front();
        checks++;
        if (out_imm_w !== e[63:0] || out_fmt_err_w !== e[64]) begin
          failures++;
          $display("FAIL rnd64_beat cyc=%0d got imm=%h err=%b want %h/%b", cyc, out_imm_w, out_fmt_err_w, e[63:0], e[64]);
        end
      end
      if (acc_a) begin
        e = model(in_instr, in_imm_sel, 1'b0, 1'b0);
        qa.push_back(e);
        if (e[64]) ecnt_a++;
      end
      if (acc_w) begin
        e = model(in_instr_w, in_imm_sel_w, 1'b1, 1'b1);
        qw.push_back(e);
        if (e[64]) ecnt_w++;
      end
    end
    checks++;
    if (qa.size() != 0 || qw.size() != 0 || out_valid_a !== 1'b0 || out_valid_w !== 1'b0) begin
      failures++;
      $display("FAIL rnd_drain got q=%0d/%0d v=%b/%b want 0/0/0/0", qa.size(), qw.size(), out_valid_a, out_valid_w);
    end
    checks++;
    if (err_cnt_a !== 16'(ecnt_a) || err_cnt_w !== 16'(ecnt_w) ||
        err_cnt_s !== ((ecnt_a > 15) ? 4'hF : 4'(ecnt_a))) begin
      failures++;
      $display("FAIL rnd_err_cnt got %0d/%0d/%0d want %0d/%0d/%0d", err_cnt_a, err_cnt_w, err_cnt_s,
               ecnt_a, ecnt_w, (ecnt_a > 15) ? 15 : ecnt_a);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_i_format();
    test_buj_formats();
    test_back_to_back();
    test_err_cnt();
    test_auto_decode64();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
